instruction_fetch_stage: RTL and testbench

Fetch stage and IF/ID pipeline register for the MIPS core. Holds the program counter, fetches instruction words from instruction memory with a request/valid handshake, and registers each returned word together with PC+4. It presents `IDOP`/`IDFunction` directly to the decode control unit. Redirects from branch, jump or JR resolution flush the register, and downstream stalls freeze it.

---
 rtl/instruction_fetch_stage.sv | 106 ++++++++++
 tb/tb_instruction_fetch_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_stage.sv
// MIPS fetch stage: program counter, instruction-memory request/valid handshake,
// and the IF/ID pipeline register with flush-on-redirect and hold-on-stall.
`timescale 1ns/1ps
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        InstrReq,
  output logic [31:0] InstrAddr,
  input  logic        InstrValid,
  input  logic [31:0] InstrData,
  output logic [31:0] PC,
  output logic        IDValid,
  output logic [31:0] IDInstruction,
  output logic [5:0]  IDOP,
  output logic [5:0]  IDFunction,
  output logic [31:0] IDPCPlus4
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HOLD,
    S_FLUSH
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic        r_id_valid;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc_plus4;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_redirect_pc;
  logic        w_held;
  logic        w_redirect_take;
  logic        w_transfer;

  assign w_pc_plus4      = r_pc + 32'd4;
  assign w_redirect_pc   = RedirectPC & ~32'h0000_0003;
  assign w_held          = r_id_valid & Stall;
  assign w_redirect_take = Redirect & ((r_state == S_RUN) | (r_state == S_HOLD));
  assign w_transfer      = InstrReq & InstrValid;

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned; an unassigned path would infer a latch.
  always_comb begin
    w_next_state = r_state;
    InstrReq     = 1'b0;
    case (r_state)
      S_BOOT:  w_next_state = S_RUN;
      S_FLUSH: w_next_state = S_RUN;
      S_RUN, S_HOLD: begin
        InstrReq = (r_state == S_RUN) & ~Redirect & ~w_held;
        if (Redirect)    w_next_state = S_FLUSH;
        else if (w_held) w_next_state = S_HOLD;
        else             w_next_state = S_RUN;
      end
      default: w_next_state = S_BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Redirect beats transfer, which beats the stall hold; otherwise a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc          <= RESET_PC;
      r_id_valid    <= 1'b0;
      r_id_instr    <= 32'd0;
      r_id_pc_plus4 <= 32'd0;
    end else if (w_redirect_take) begin
      r_pc       <= w_redirect_pc;
      r_id_valid <= 1'b0;
    end else if (w_transfer) begin
      r_pc          <= w_pc_plus4;
      r_id_valid    <= 1'b1;
      r_id_instr    <= InstrData;
      r_id_pc_plus4 <= w_pc_plus4;
    end else if (!w_held) begin
      r_id_valid <= 1'b0;
    end
  end

  assign InstrAddr     = r_pc;
  assign PC            = r_pc;
  assign IDValid       = r_id_valid;
  assign IDInstruction = r_id_instr;
  assign IDOP          = r_id_instr[31:26];
  assign IDFunction    = r_id_instr[5:0];
  assign IDPCPlus4     = r_id_pc_plus4;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage: stimulus pushes expected IF/ID
// contents into a scoreboard that a monitor pops on each memory handshake.
`timescale 1ns/1ps
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        InstrReq;
  logic [31:0] InstrAddr;
  logic        InstrValid;
  logic [31:0] InstrData;
  logic [31:0] PC;
  logic        IDValid;
  logic [31:0] IDInstruction;
  logic [5:0]  IDOP;
  logic [5:0]  IDFunction;
  logic [31:0] IDPCPlus4;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  instruction_fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .reset        (reset),
    .Stall        (Stall),
    .Redirect     (Redirect),
    .RedirectPC   (RedirectPC),
    .InstrReq     (InstrReq),
    .InstrAddr    (InstrAddr),
    .InstrValid   (InstrValid),
    .InstrData    (InstrData),
    .PC           (PC),
    .IDValid      (IDValid),
    .IDInstruction(IDInstruction),
    .IDOP         (IDOP),
    .IDFunction   (IDFunction),
    .IDPCPlus4    (IDPCPlus4)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Instruction memory contents: the boot word, then an address-derived pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h2008_0005;
    return {a[15:0], ~a[31:16]};
  endfunction

  assign InstrData = mem_word(InstrAddr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] addr, input logic [31:0] pc4);
    exp_t e;
    e.instr = mem_word(addr);
    e.pc4   = pc4;
    sb_q.push_back(e);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pc"},    PC,            RST_PC);
    check({tag, "_addr"},  InstrAddr,     RST_PC);
    check({tag, "_req"},   {31'd0, InstrReq}, 32'd0);
    check({tag, "_valid"}, {31'd0, IDValid},  32'd0);
    check({tag, "_instr"}, IDInstruction, 32'd0);
    check({tag, "_pc4"},   IDPCPlus4,     32'd0);
  endtask

  // Monitor: a handshake sampled at an edge must load the next scoreboard entry.
  always @(posedge clk) begin
    exp_t e;
    if (reset && InstrReq && InstrValid) begin
      #1;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected_transfer actual_pc4=%h expected=none at %0t", IDPCPlus4, $time);
      end else begin
        e = sb_q.pop_front();
        check("sb_instr", IDInstruction, e.instr);
        check("sb_pc4",   IDPCPlus4,     e.pc4);
        check("sb_valid", {31'd0, IDValid}, 32'd1);
        check("sb_op",    {26'd0, IDOP},       {26'd0, e.instr[31:26]});
        check("sb_fn",    {26'd0, IDFunction}, {26'd0, e.instr[5:0]});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; Stall = 1'b0; Redirect = 1'b0; RedirectPC = 32'd0; InstrValid = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("rst");

    // Boot and streaming with zero-wait memory
    reset = 1'b1;
    #1 check("boot_req", {31'd0, InstrReq}, 32'd0);
    @(negedge clk);
    check("run_req",  {31'd0, InstrReq}, 32'd1);
    check("run_addr", InstrAddr, 32'h0040_0000);
    push(32'h0040_0000, 32'h0040_0004);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("stream_valid", {31'd0, IDValid}, 32'd1);
      check("stream_pc", PC, 32'h0040_0000 + 32'(4 * i));
      if (i == 1) begin
        check("boot_op", {26'd0, IDOP},       32'h08);
        check("boot_fn", {26'd0, IDFunction}, 32'h05);
      end
      push(32'h0040_0000 + 32'(4 * i), 32'h0040_0004 + 32'(4 * i));
    end

    // Stall for three edges with IF/ID valid
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      Stall = 1'b1;
      #1;
      check("stall_req",   {31'd0, InstrReq}, 32'd0);
      check("stall_pc",    PC, 32'h0040_0014);
      check("stall_valid", {31'd0, IDValid}, 32'd1);
      check("stall_pc4",   IDPCPlus4, 32'h0040_0014);
      check("stall_instr", IDInstruction, mem_word(32'h0040_0010));
    end
    @(negedge clk);
    check("stall_end_pc4", IDPCPlus4, 32'h0040_0014);
    check("stall_end_pc",  PC, 32'h0040_0014);
    Stall = 1'b0;
    #1 check("hold_exit_req", {31'd0, InstrReq}, 32'd0);
    @(negedge clk);
    check("bubble_valid", {31'd0, IDValid}, 32'd0);
    check("resume_req",   {31'd0, InstrReq}, 32'd1);
    check("resume_addr",  InstrAddr, 32'h0040_0014);
    push(32'h0040_0014, 32'h0040_0018);
    @(negedge clk);
    check("resume_valid", {31'd0, IDValid}, 32'd1);
    check("resume_pc",    PC, 32'h0040_0018);

    // Redirect while held, memory also valid
    Stall = 1'b1;
    @(negedge clk);
    Redirect = 1'b1; RedirectPC = 32'h0040_0103;
    #1 check("redir_req", {31'd0, InstrReq}, 32'd0);
    @(negedge clk);
    check("redir_valid", {31'd0, IDValid}, 32'd0);
    check("redir_pc",    PC, 32'h0040_0100);
    check("flush_req",   {31'd0, InstrReq}, 32'd0);
    Stall = 1'b0; RedirectPC = 32'h1234_5678;
    @(negedge clk);
    check("flush_ignore_pc", PC, 32'h0040_0100);
    Redirect = 1'b0;
    #1;
    check("redir_fetch_req",  {31'd0, InstrReq}, 32'd1);
    check("redir_fetch_addr", InstrAddr, 32'h0040_0100);
    push(32'h0040_0100, 32'h0040_0104);
    @(negedge clk);
    check("redir_done_pc",    PC, 32'h0040_0104);
    check("redir_done_valid", {31'd0, IDValid}, 32'd1);

    // Redirect to the top of the address space, then memory wait and wrap
    Redirect = 1'b1; RedirectPC = 32'hFFFF_FFFE;
    #1 check("wrap_redir_req", {31'd0, InstrReq}, 32'd0);
    @(negedge clk);
    check("wrap_pc", PC, 32'hFFFF_FFFC);
    Redirect = 1'b0; InstrValid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("wait_addr",  InstrAddr, 32'hFFFF_FFFC);
      check("wait_valid", {31'd0, IDValid}, 32'd0);
      check("wait_req",   {31'd0, InstrReq}, 32'd1);
      @(negedge clk);
    end
    check("wait_end_addr", InstrAddr, 32'hFFFF_FFFC);
    InstrValid = 1'b1;
    push(32'hFFFF_FFFC, 32'h0000_0000);
    @(negedge clk);
    check("wrap_pc_zero", PC, 32'h0000_0000);
    check("wrap_valid",   {31'd0, IDValid}, 32'd1);
    push(32'h0000_0000, 32'h0000_0004);
    @(negedge clk);
    check("post_wrap_pc", PC, 32'h0000_0004);

    // Asynchronous reset mid-stream, across an edge with a pending fetch
    #2 reset = 1'b0;
    #1 check_reset_values("async_rst");
    @(negedge clk);
    check_reset_values("rst_held");
    reset = 1'b1;
    #1 check("reboot_req", {31'd0, InstrReq}, 32'd0);
    @(negedge clk);
    check("reboot_addr", InstrAddr, 32'h0040_0000);
    push(32'h0040_0000, 32'h0040_0004);
    @(negedge clk);
    check("reboot_pc",    PC, 32'h0040_0004);
    check("reboot_valid", {31'd0, IDValid}, 32'd1);
    InstrValid = 1'b0;
    repeat (2) @(negedge clk);
    check("sb_drained", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
